// File: rtl/conv_window_sched.sv
// Sequences the 3x3 conv engine over an IMG_H x IMG_W image for NUM_K kernels:
// loads coefficients, fetches and issues every valid window, captures results.
module conv_window_sched #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned NUM_K = 4,
  parameter int unsigned IA_W  = 10,
  parameter int unsigned CA_W  = 8,
  parameter int unsigned RA_W  = 12
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  output logic [IA_W-1:0] o_img_addr,
  input  logic [7:0]      i_img_data,
  output logic [CA_W-1:0] o_coef_addr,
  input  logic [7:0]      i_coef_data,
  output logic [71:0]     o_pixel_data,
  output logic            o_pixel_data_valid,
  output logic [71:0]     o_weight,
  output logic [7:0]      o_bias,
  input  logic [7:0]      i_conv_data,
  input  logic            i_conv_valid,
  output logic            o_res_we,
  output logic [RA_W-1:0] o_res_addr,
  output logic [7:0]      o_res_data
);

  localparam int unsigned OW        = IMG_W - 2;
  localparam int unsigned OH        = IMG_H - 2;
  localparam int unsigned WIN_PER_K = OH * OW;
  localparam int unsigned XW        = $clog2(IMG_W);
  localparam int unsigned YW        = $clog2(IMG_H);
  localparam int unsigned KW        = (NUM_K > 1) ? $clog2(NUM_K) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOADK, S_FETCH, S_ISSUE, S_DRAIN, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [YW-1:0]   y_q, y_d;
  logic [XW-1:0]   x_q, x_d;
  logic [1:0]      r_q, r_d, c_q, c_d;
  logic [3:0]      lc_q, lc_d;
  logic [71:0]     shadow_q, shadow_d;
  logic [RA_W-1:0] wcnt_q, wcnt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [IA_W-1:0] img_addr_q, img_addr_d;
  logic [CA_W-1:0] coef_addr_q, coef_addr_d;
  logic [71:0]     pix_q, pix_d, weight_q, weight_d;
  logic            pv_q, pv_d;
  logic [7:0]      bias_q, bias_d;
  logic            res_we_q, res_we_d;
  logic [RA_W-1:0] res_addr_q, res_addr_d;
  logic [7:0]      res_data_q, res_data_d;

  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_img_addr         = img_addr_q;
  assign o_coef_addr        = coef_addr_q;
  assign o_pixel_data       = pix_q;
  assign o_pixel_data_valid = pv_q;
  assign o_weight           = weight_q;
  assign o_bias             = bias_q;
  assign o_res_we           = res_we_q;
  assign o_res_addr         = res_addr_q;
  assign o_res_data         = res_data_q;

  // Next-state and output logic; addresses are registered one cycle ahead of use.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    y_d         = y_q;
    x_d         = x_q;
    r_d         = r_q;
    c_d         = c_q;
    lc_d        = lc_q;
    shadow_d    = shadow_q;
    wcnt_d      = wcnt_q;
    img_addr_d  = img_addr_q;
    coef_addr_d = coef_addr_q;
    pix_d       = pix_q;
    pv_d        = 1'b0;
    weight_d    = weight_q;
    bias_d      = bias_q;
    res_we_d    = 1'b0;
    res_addr_d  = res_addr_q;
    res_data_d  = res_data_q;

    if (i_conv_valid) begin
      res_we_d   = 1'b1;
      res_data_d = i_conv_data;
      res_addr_d = wcnt_q;
      wcnt_d     = wcnt_q + RA_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_LOADK;
          k_d         = '0;
          y_d         = '0;
          x_d         = '0;
          lc_d        = '0;
          wcnt_d      = '0;
          coef_addr_d = '0;
        end
      end
      S_LOADK: begin
        // Data for the address shown at lc-1 arrives at lc; weights shift in byte 0 first.
        if (lc_q == 4'd10) begin
          bias_d = i_coef_data;
        end else if (lc_q != 4'd0) begin
          weight_d = {i_coef_data, weight_q[71:8]};
        end
        if (lc_q < 4'd9) begin
          coef_addr_d = CA_W'(32'(k_q) * 32'd10 + 32'(lc_q) + 32'd1);
        end
        if (lc_q == 4'd10) begin
          state_d = S_FETCH;
          r_d     = '0;
          c_d     = '0;
        end else begin
          lc_d = lc_q + 4'd1;
        end
      end
      S_FETCH: begin
        if (!(r_q == 2'd0 && c_q == 2'd0)) begin
          shadow_d = {i_img_data, shadow_q[71:8]};
        end
        if (r_q == 2'd2 && c_q == 2'd2) begin
          state_d = S_ISSUE;
        end else if (c_q == 2'd2) begin
          c_d = '0;
          r_d = r_q + 2'd1;
        end else begin
          c_d = c_q + 2'd1;
        end
      end
      S_ISSUE: begin
        pix_d = {i_img_data, shadow_q[71:8]};
        pv_d  = 1'b1;
        r_d   = '0;
        c_d   = '0;
        if (x_q == XW'(OW - 1)) begin
          x_d = '0;
          y_d = y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
        if (x_q == XW'(OW - 1) && y_q == YW'(OH - 1)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        // Hold coefficients until every issued window of this kernel is written back.
        if (wcnt_q == RA_W'((32'(k_q) + 32'd1) * WIN_PER_K)) begin
          if (k_q == KW'(NUM_K - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_LOADK;
            k_d         = k_q + KW'(1);
            y_d         = '0;
            x_d         = '0;
            lc_d        = '0;
            coef_addr_d = CA_W'((32'(k_q) + 32'd1) * 32'd10);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_FETCH) begin
      img_addr_d = IA_W'((32'(y_d) + 32'(r_d)) * IMG_W + 32'(x_d) + 32'(c_d));
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      y_q         <= '0;
      x_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      lc_q        <= '0;
      shadow_q    <= '0;
      wcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      img_addr_q  <= '0;
      coef_addr_q <= '0;
      pix_q       <= '0;
      pv_q        <= 1'b0;
      weight_q    <= '0;
      bias_q      <= '0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      y_q         <= y_d;
      x_q         <= x_d;
      r_q         <= r_d;
      c_q         <= c_d;
      lc_q        <= lc_d;
      shadow_q    <= shadow_d;
      wcnt_q      <= wcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      img_addr_q  <= img_addr_d;
      coef_addr_q <= coef_addr_d;
      pix_q       <= pix_d;
      pv_q        <= pv_d;
      weight_q    <= weight_d;
      bias_q      <= bias_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched: RAM and engine models around the DUT, with results,
// windows and coefficients checked against a direct arithmetic model of the image.
module tb_conv_window_sched;

  localparam int unsigned IMG_W = 28, IMG_H = 28, NUM_K = 4;
  localparam int unsigned IA_W = 10, CA_W = 8, RA_W = 12;
  localparam int unsigned OW = IMG_W - 2, OH = IMG_H - 2;
  localparam int unsigned NWIN = OH * OW, NRES = NUM_K * NWIN;
  localparam int unsigned NPIX = IMG_W * IMG_H, NCOEF = NUM_K * 10;

  logic            i_clk = 1'b0, i_rst = 1'b0, i_start = 1'b0;
  logic            o_busy, o_done, o_pixel_data_valid, o_res_we, i_conv_valid;
  logic [IA_W-1:0] o_img_addr;
  logic [CA_W-1:0] o_coef_addr;
  logic [7:0]      i_img_data = '0, i_coef_data = '0, o_bias, i_conv_data, o_res_data;
  logic [71:0]     o_pixel_data, o_weight;
  logic [RA_W-1:0] o_res_addr;

  conv_window_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_K(NUM_K),
                      .IA_W(IA_W), .CA_W(CA_W), .RA_W(RA_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_img_addr(o_img_addr), .i_img_data(i_img_data),
    .o_coef_addr(o_coef_addr), .i_coef_data(i_coef_data),
    .o_pixel_data(o_pixel_data), .o_pixel_data_valid(o_pixel_data_valid),
    .o_weight(o_weight), .o_bias(o_bias),
    .i_conv_data(i_conv_data), .i_conv_valid(i_conv_valid),
    .o_res_we(o_res_we), .o_res_addr(o_res_addr), .o_res_data(o_res_data));

  always #5 i_clk = ~i_clk;

  initial assert (NUM_K * OH * OW <= 2 ** RA_W) else $error("result space too small");

  int unsigned img_mem [NPIX];
  int unsigned coef_mem [NCOEF];
  logic [7:0]  res_mem [NRES];
  int vectors = 0, miscompares = 0;

  // Synchronous-read memories: data valid the cycle after the address.
  always @(posedge i_clk) begin
    i_img_data  <= (32'(o_img_addr) < NPIX) ? 8'(img_mem[o_img_addr]) : 8'h00;
    i_coef_data <= (32'(o_coef_addr) < NCOEF) ? 8'(coef_mem[o_coef_addr]) : 8'h00;
  end

  function automatic logic [7:0] sat8(input int unsigned a);
    return (a > 255) ? 8'd255 : 8'(a);
  endfunction

  function automatic logic [7:0] engine(input logic [71:0] p, input logic [71:0] w,
                                        input logic [7:0] b);
    int unsigned acc = 32'(b);
    for (int i = 0; i < 9; i++) acc += 32'(p[i*8 +: 8]) * 32'(w[i*8 +: 8]);
    return sat8(acc);
  endfunction

  // Engine model: result valid three cycles after a window valid, cleared by reset.
  logic [7:0] e_d1, e_d2, e_d3;
  logic       e_v1, e_v2, e_v3;
  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      {e_v1, e_v2, e_v3} <= '0;
      {e_d1, e_d2, e_d3} <= '0;
    end else begin
      e_v1 <= o_pixel_data_valid;
      e_d1 <= engine(o_pixel_data, o_weight, o_bias);
      e_v2 <= e_v1; e_d2 <= e_d1;
      e_v3 <= e_v2; e_d3 <= e_d2;
    end
  end
  assign i_conv_valid = e_v3;
  assign i_conv_data  = e_d3;

  function automatic logic [7:0] gold(input int idx);
    int k = idx / NWIN, y = (idx % NWIN) / OW, x = idx % OW;
    int unsigned acc = coef_mem[k*10 + 9];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc += img_mem[(y + r) * IMG_W + x + c] * coef_mem[k*10 + r*3 + c];
    return sat8(acc);
  endfunction

  function automatic logic [71:0] exp_win(input int n);
    logic [71:0] w = '0;
    int y = n / OW, x = n % OW;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3 + c)*8 +: 8] = 8'(img_mem[(y + r) * IMG_W + x + c]);
    return w;
  endfunction

  function automatic logic [71:0] exp_wgt(input int k);
    logic [71:0] w = '0;
    for (int j = 0; j < 9; j++) w[j*8 +: 8] = 8'(coef_mem[k*10 + j]);
    return w;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model; counters restart when a run raises o_busy.
  int cyc = 0, last_pv = 0, win_cnt = 0, win_k = 0, issued = 0, exp_wcnt = 0, done_cnt = 0;
  logic busy_prev = 1'b0;
  logic [71:0] first_win = '0, second_win = '0;
  always @(negedge i_clk) begin
    cyc++;
    if (!i_rst) begin
      busy_prev = 1'b0;
    end else begin
      if (o_busy && !busy_prev) begin
        exp_wcnt = 0; win_cnt = 0; win_k = 0; issued = 0; done_cnt = 0;
      end
      busy_prev = o_busy;
      if (o_pixel_data_valid) begin
        chk("window", o_pixel_data, exp_win(win_cnt));
        chk("weight_at_issue", o_weight, exp_wgt(win_k));
        chk("bias_at_issue", 72'(o_bias), 72'(coef_mem[win_k*10 + 9]));
        if (win_cnt > 0) chk("issue_spacing", 72'(cyc - last_pv), 72'd10);
        if (win_k == 0 && win_cnt == 0) first_win = o_pixel_data;
        if (win_k == 0 && win_cnt == 1) second_win = o_pixel_data;
        last_pv = cyc;
        issued++;
        win_cnt++;
        if (win_cnt == NWIN) begin win_cnt = 0; win_k++; end
      end
      if (issued > exp_wcnt && exp_wcnt < NRES) begin
        chk("weight_stable", o_weight, exp_wgt(exp_wcnt / NWIN));
        chk("bias_stable", 72'(o_bias), 72'(coef_mem[(exp_wcnt / NWIN)*10 + 9]));
      end
      if (o_res_we) begin
        chk("busy_during_write", 72'(o_busy), 72'd1);
        chk("res_addr", 72'(o_res_addr), 72'(exp_wcnt));
        if (exp_wcnt < NRES) begin
          chk("res_data", 72'(o_res_data), 72'(gold(exp_wcnt)));
          res_mem[o_res_addr] = o_res_data;
        end else begin
          chk("res_count_overflow", 72'(exp_wcnt), 72'(NRES - 1));
        end
        exp_wcnt++;
      end
      if (o_done) begin
        done_cnt++;
        chk("writes_at_done", 72'(exp_wcnt), 72'(NRES));
        chk("busy_low_at_done", 72'(o_busy), 72'd0);
      end
    end
  end

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!o_done && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no o_done within %0d cycles", limit);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, 72'({o_busy, o_done, o_pixel_data_valid, o_res_we}), 72'd0);
    chk({name, "_addr"}, 72'({o_img_addr, o_coef_addr, o_res_addr}), 72'd0);
    chk({name, "_pix"}, o_pixel_data, 72'd0);
    chk({name, "_wgt"}, o_weight, 72'd0);
    chk({name, "_bias_res"}, 72'({o_bias, o_res_data}), 72'd0);
  endtask

  initial begin
    // Run 1 data: pixel = (y*W+x) mod 256, centre-tap identity kernels, kernel 1 bias 3.
    for (int i = 0; i < NPIX; i++) img_mem[i] = i % 256;
    for (int k = 0; k < NUM_K; k++)
      for (int j = 0; j < 10; j++)
        coef_mem[k*10 + j] = (j == 4) ? 1 : ((j == 9 && k == 1) ? 3 : 0);

    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst = 1'b1;
    @(negedge i_clk);

    // Abort a run mid-fetch with reset.
    pulse_start();
    repeat (30) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      chk("idle_after_reset", 72'({o_busy, o_res_we}), 72'd0);
    end

    // Run 1.
    pulse_start();
    chk("busy_after_start", 72'(o_busy), 72'd1);
    wait_done(40000);
    @(negedge i_clk);
    chk("done_once_run1", 72'(done_cnt), 72'd1);
    chk("first_window", first_win, 72'h3a_39_38_1e_1d_1c_02_01_00);
    chk("second_window", second_win, 72'h3b_3a_39_1f_1e_1d_03_02_01);
    chk("res0", 72'(res_mem[0]), 72'd29);
    chk("res1", 72'(res_mem[1]), 72'd30);
    chk("res26", 72'(res_mem[26]), 72'd57);
    chk("res676_bias", 72'(res_mem[676]), 72'd32);
    chk("res886_sat", 72'(res_mem[886]), 72'd255);
    chk("res2703", 72'(res_mem[2703]), 72'd242);

    // Run 2: random data, started the cycle after o_done, with a start while busy.
    for (int i = 0; i < NPIX; i++) img_mem[i] = $urandom_range(0, 255);
    for (int k = 0; k < NUM_K; k++) begin
      for (int j = 0; j < 9; j++) coef_mem[k*10 + j] = ($urandom_range(0, 3) == 0) ? 1 : 0;
      coef_mem[k*10 + 9] = $urandom_range(0, 255);
    end
    pulse_start();
    chk("restart_after_done", 72'(o_busy), 72'd1);
    repeat (49) @(negedge i_clk);
    pulse_start();
    chk("start_while_busy", 72'(o_busy), 72'd1);
    wait_done(40000);
    repeat (5) @(negedge i_clk);
    chk("done_once_run2", 72'(done_cnt), 72'd1);
    chk("idle_after_run2", 72'({o_busy, o_res_we}), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
